// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with write ack, overflow/underflow pulses, occupancy count
// and margin-based almost flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_MARGIN  = 1,
    parameter int unsigned AE_MARGIN  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [FIFO_WIDTH-1:0]               data_in,
    input  logic                                wr_en,
    input  logic                                rd_en,
    output logic [FIFO_WIDTH-1:0]               data_out,
    output logic                                wr_ack,
    output logic                                overflow,
    output logic                                underflow,
    output logic                                full,
    output logic                                empty,
    output logic                                almostfull,
    output logic                                almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign wr_acc = wr_en & (~full | rd_en);
    assign rd_acc = rd_en & ~empty;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign almostfull  = (count >= CW'(FIFO_DEPTH - AF_MARGIN)) && !full;
    assign almostempty = !empty && (count <= CW'(AE_MARGIN));

    // Pointers, occupancy and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    // Storage is not cleared by reset, but reset still blocks a concurrent write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr];
`else
    logic [FIFO_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= mem[rd_ptr];
        end
    end

    assign data_out = data_q;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param: default 8-deep instance plus a
// 5-deep instance for non-power-of-two pointer wrap.
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] data_out;
    logic        wr_ack;
    logic        overflow;
    logic        underflow;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;
    logic [3:0]  count;

    logic [15:0] d5_data_in;
    logic        d5_wr_en;
    logic        d5_rd_en;
    logic [15:0] d5_data_out;
    logic        d5_wr_ack;
    logic        d5_overflow;
    logic        d5_underflow;
    logic        d5_full;
    logic        d5_empty;
    logic        d5_almostfull;
    logic        d5_almostempty;
    logic [2:0]  d5_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .count(count)
    );

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(1), .AE_MARGIN(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .data_in(d5_data_in), .wr_en(d5_wr_en), .rd_en(d5_rd_en),
        .data_out(d5_data_out), .wr_ack(d5_wr_ack), .overflow(d5_overflow),
        .underflow(d5_underflow), .full(d5_full), .empty(d5_empty),
        .almostfull(d5_almostfull), .almostempty(d5_almostempty), .count(d5_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [26:0] exp_st;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        d5_wr_en = 1'b0; d5_rd_en = 1'b0; d5_data_in = '0;
        tick();
        exp_st = {4'd0, 7'b0100000, 16'h0000};
        checks++;
        if ({count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, data_out} !== exp_st) begin
            errors++;
            $display("FAIL reset_init: got %h expected %h",
                     {count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, data_out}, exp_st);
        end
        checks++;
        if ({d5_count, d5_empty, d5_data_out} !== {3'd0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_d5: count=%0d empty=%b data_out=%h expected 0/1/0000", d5_count, d5_empty, d5_data_out);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data_in = 16'h0A00 + 16'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL reset_pre_count: got %0d expected 5", count);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (data_out !== 16'h0A01) begin
            errors++;
            $display("FAIL reset_pre_data: got %h expected 0a01", data_out);
        end
`endif
        // reset asserted while both requests are active
        rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hFFFF;
        tick();
        checks++;
        if ({count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, data_out} !== exp_st) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h",
                     {count, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, data_out}, exp_st);
        end
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        checks++;
        if ({count, empty} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: count=%0d empty=%b expected 0/1", count, empty);
        end
    endtask

    task automatic test_write_full();
        logic [10:0] exp_st;
        for (int i = 1; i <= 8; i++) begin
            data_in = 16'(i); wr_en = 1'b1;
            tick();
            exp_st = {4'(i), 1'(i == 8), 1'b0, 1'(i == 7), 1'(i == 1), 1'b1, 1'b0};
            checks++;
            if ({count, full, empty, almostfull, almostempty, wr_ack, overflow} !== exp_st) begin
                errors++;
                $display("FAIL write_%0d: got %b expected %b", i,
                         {count, full, empty, almostfull, almostempty, wr_ack, overflow}, exp_st);
            end
        end
        data_in = 16'h0009;
        tick();
        checks++;
        if ({count, full, wr_ack, overflow} !== {4'd8, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow: count=%0d full=%b wr_ack=%b overflow=%b expected 8/1/0/1",
                     count, full, wr_ack, overflow);
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if ({wr_ack, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL overflow_pulse: wr_ack=%b overflow=%b expected 0/0", wr_ack, overflow);
        end
    endtask

    task automatic test_read_empty();
        logic [6:0] exp_st;
        for (int k = 1; k <= 8; k++) begin
`ifdef FIFO_FWFT_EN
            checks++;
            if (data_out !== 16'(k)) begin
                errors++;
                $display("FAIL fwft_show_%0d: got %h expected %h", k, data_out, 16'(k));
            end
`endif
            rd_en = 1'b1;
            tick();
            exp_st = {4'(8 - k), 1'(k == 8), 1'(k == 7), 1'b0};
            checks++;
            if ({count, empty, almostempty, underflow} !== exp_st) begin
                errors++;
                $display("FAIL read_flags_%0d: got %b expected %b", k,
                         {count, empty, almostempty, underflow}, exp_st);
            end
`ifndef FIFO_FWFT_EN
            checks++;
            if (data_out !== 16'(k)) begin
                errors++;
                $display("FAIL read_data_%0d: got %h expected %h", k, data_out, 16'(k));
            end
`endif
        end
        tick();
        checks++;
`ifdef FIFO_FWFT_EN
        if ({count, underflow, data_out} !== {4'd0, 1'b1, 16'h0000}) begin
`else
        if ({count, underflow, data_out} !== {4'd0, 1'b1, 16'h0008}) begin
`endif
            errors++;
            $display("FAIL underflow: count=%0d underflow=%b data_out=%h", count, underflow, data_out);
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse: got %b expected 0", underflow);
        end
    endtask

    task automatic test_full_rw();
        logic [15:0] exp_d;
        for (int i = 1; i <= 8; i++) begin
            data_in = 16'h0010 + 16'(i); wr_en = 1'b1;
            tick();
        end
        data_in = 16'hAAAA; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({count, wr_ack, overflow, underflow} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_rw: count=%0d wr_ack=%b overflow=%b underflow=%b expected 8/1/0/0",
                     count, wr_ack, overflow, underflow);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (data_out !== 16'h0011) begin
            errors++;
            $display("FAIL full_rw_data: got %h expected 0011", data_out);
        end
`endif
        for (int j = 1; j <= 8; j++) begin
            exp_d = (j < 8) ? 16'h0011 + 16'(j) : 16'hAAAA;
`ifdef FIFO_FWFT_EN
            checks++;
            if (data_out !== exp_d) begin
                errors++;
                $display("FAIL full_rw_drain_%0d: got %h expected %h", j, data_out, exp_d);
            end
`endif
            rd_en = 1'b1;
            tick();
`ifndef FIFO_FWFT_EN
            checks++;
            if (data_out !== exp_d) begin
                errors++;
                $display("FAIL full_rw_drain_%0d: got %h expected %h", j, data_out, exp_d);
            end
`endif
        end
        // empty with both requests: write only, no bypass
        data_in = 16'h5555; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if ({count, wr_ack, underflow, empty} !== {4'd1, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL empty_rw: count=%0d wr_ack=%b underflow=%b empty=%b expected 1/1/1/0",
                     count, wr_ack, underflow, empty);
        end
        checks++;
`ifdef FIFO_FWFT_EN
        if (data_out !== 16'h5555) begin
`else
        if (data_out !== 16'hAAAA) begin
`endif
            errors++;
            $display("FAIL empty_rw_data: got %h", data_out);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
`ifdef FIFO_FWFT_EN
        if ({count, data_out} !== {4'd0, 16'h0000}) begin
`else
        if ({count, data_out} !== {4'd0, 16'h5555}) begin
`endif
            errors++;
            $display("FAIL empty_rw_pop: count=%0d data_out=%h", count, data_out);
        end
    endtask

    task automatic test_wrap_d5();
        logic [15:0] exp_d;
        logic [15:0] tail [5];
        tail = '{16'h0114, 16'h0115, 16'h0200, 16'h0201, 16'h0202};
        for (int i = 0; i < 2; i++) begin
            d5_data_in = 16'h0100 + 16'(i); d5_wr_en = 1'b1;
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            exp_d = 16'h0100 + 16'(i);
            d5_data_in = 16'h0102 + 16'(i); d5_wr_en = 1'b1; d5_rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
            checks++;
            if (d5_data_out !== exp_d) begin
                errors++;
                $display("FAIL wrap_pair_%0d: got %h expected %h", i, d5_data_out, exp_d);
            end
`endif
            tick();
            checks++;
`ifdef FIFO_FWFT_EN
            if (d5_count !== 3'd2) begin
`else
            if ({d5_count, d5_data_out} !== {3'd2, exp_d}) begin
`endif
                errors++;
                $display("FAIL wrap_pair_%0d: count=%0d data_out=%h expected 2/%h", i, d5_count, d5_data_out, exp_d);
            end
        end
        d5_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d5_data_in = 16'h0200 + 16'(i); d5_wr_en = 1'b1;
            tick();
            checks++;
            if ({d5_count, d5_full, d5_almostfull} !== {3'(3 + i), 1'(i == 2), 1'(i == 1)}) begin
                errors++;
                $display("FAIL wrap_fill_%0d: count=%0d full=%b af=%b", i, d5_count, d5_full, d5_almostfull);
            end
        end
        d5_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
`ifdef FIFO_FWFT_EN
            checks++;
            if (d5_data_out !== tail[i]) begin
                errors++;
                $display("FAIL wrap_drain_%0d: got %h expected %h", i, d5_data_out, tail[i]);
            end
`endif
            d5_rd_en = 1'b1;
            tick();
`ifndef FIFO_FWFT_EN
            checks++;
            if (d5_data_out !== tail[i]) begin
                errors++;
                $display("FAIL wrap_drain_%0d: got %h expected %h", i, d5_data_out, tail[i]);
            end
`endif
        end
        d5_rd_en = 1'b0;
        checks++;
        if ({d5_count, d5_empty} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_end: count=%0d empty=%b expected 0/1", d5_count, d5_empty);
        end
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        checks++;
        if ({empty, data_out} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL fwft_idle: empty=%b data_out=%h expected 1/0000", empty, data_out);
        end
        data_in = 16'hBEEF; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++;
        if ({empty, data_out} !== {1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL fwft_show: empty=%b data_out=%h expected 0/beef", empty, data_out);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({empty, data_out} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL fwft_pop: empty=%b data_out=%h expected 1/0000", empty, data_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_full();
        test_read_empty();
        test_full_rw();
        test_wrap_d5();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
